// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame packer.
// Contents:
//   ADC_W          - width of one ADC sample word
//   FRAME_LEN      - number of bytes in one output frame
//   DEFAULT_HEADER - default first byte of every frame
//   frame_state_e  - byte-sequencer states; IDLE first, then bytes in wire order
//   frame_csum     - XOR checksum over the five bytes that precede it in a frame
package adc_pkg;

  localparam int         ADC_W          = 24;
  localparam int         FRAME_LEN      = 6;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_D2   = 3'd3,
    ST_D1   = 3'd4,
    ST_D0   = 3'd5,
    ST_CSUM = 3'd6
  } frame_state_e;

  function automatic logic [7:0] frame_csum(input logic [7:0]       hdr,
                                            input logic [7:0]       seq,
                                            input logic [ADC_W-1:0] data);
    return hdr ^ seq ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/adc_avg_decim.sv
// Edge detector plus block averager / decimator for the ADC sample stream.
// Every rising edge of sample_ready (while enable is high) is one event.
// Each event adds the sign-extended sample to an accumulator; the
// 2^AVG_LOG2-th event produces a result = (acc + sample) >>> AVG_LOG2.
// The result strobe is combinational so the consumer can capture the result
// on the very edge that samples the event.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   enable       - low: events ignored, accumulator and count cleared
//   sample_data  - two's-complement sample, stable while sample_ready is high
//   sample_ready - level strobe from the channel reader
//   res_valid    - one-cycle result strobe
//   res_data     - averaged result, valid with res_valid
module adc_avg_decim
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ADC_W-1:0] sample_data,
  input  logic             sample_ready,
  output logic             res_valid,
  output logic [ADC_W-1:0] res_data
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  // Keep the counter at least one bit wide so pass-through mode still elaborates.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic                    rdy_d;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic                    event_hit;
  logic                    last_hit;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [ADC_W-1:0] s);
    return ACC_W'(s);
  endfunction

  // Arithmetic shift floors toward -inf; the accumulator is wide enough that
  // the shifted value always fits back into ADC_W bits.
  function automatic logic [ADC_W-1:0] avg_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> AVG_LOG2;
    return sh[ADC_W-1:0];
  endfunction

  assign event_hit  = sample_ready & ~rdy_d & enable;
  assign last_hit   = (cnt == CNT_LAST);
  assign sample_ext = sign_extend(sample_data);
  assign sum        = acc + sample_ext;
  assign res_valid  = event_hit & last_hit;
  assign res_data   = avg_shift(sum);

  // Stage p0: edge register, accumulator and event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_d <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      rdy_d <= sample_ready;
      if (!enable) begin
        acc <= '0;
        cnt <= '0;
      end else if (event_hit) begin
        if (last_hit) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs averaged ADC results into 6-byte frames and streams them byte-wise.
// Frame: HEADER, seq, data[23:16], data[15:8], data[7:0], XOR checksum.
// A single pending entry decouples result arrival from frame transmission;
// a result that finds it occupied (and not being drained that same edge) is
// dropped and counted.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   enable       - gate for incoming samples (frames already queued still drain)
//   sample_data  - 24-bit two's-complement sample
//   sample_ready - new-sample level strobe
//   out_data     - current frame byte (0 when idle)
//   out_valid    - out_data valid
//   out_ready    - sink accepts byte on out_valid & out_ready
//   busy         - frame in progress or pending entry full
//   overflow     - sticky result-dropped flag
//   drop_count   - saturating count of dropped results
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int         AVG_LOG2 = 0,
  parameter logic [7:0] HEADER   = DEFAULT_HEADER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ADC_W-1:0] sample_data,
  input  logic             sample_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  logic             res_valid;
  logic [ADC_W-1:0] res_data;
  logic             pend_full;
  logic [ADC_W-1:0] pend_data;
  logic [ADC_W-1:0] frame_data;
  logic [7:0]       seq;
  frame_state_e     state;
  frame_state_e     state_nxt;
  logic             consume;
  logic             accept;
  logic             load;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  adc_avg_decim #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .res_valid   (res_valid),
    .res_data    (res_data)
  );

  assign consume   = (state == ST_IDLE) & pend_full;
  assign accept    = out_valid & out_ready;
  // Pending being emptied on this edge frees the slot for a same-edge result.
  assign load      = res_valid & (~pend_full | consume);
  assign out_valid = (state != ST_IDLE);
  assign busy      = out_valid | pend_full;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (consume) state_nxt = ST_HDR;
      ST_HDR:  if (accept)  state_nxt = ST_SEQ;
      ST_SEQ:  if (accept)  state_nxt = ST_D2;
      ST_D2:   if (accept)  state_nxt = ST_D1;
      ST_D1:   if (accept)  state_nxt = ST_D0;
      ST_D0:   if (accept)  state_nxt = ST_CSUM;
      ST_CSUM: if (accept)  state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data = 8'h00;
    case (state)
      ST_HDR:  out_data = HEADER;
      ST_SEQ:  out_data = seq;
      ST_D2:   out_data = frame_data[23:16];
      ST_D1:   out_data = frame_data[15:8];
      ST_D0:   out_data = frame_data[7:0];
      ST_CSUM: out_data = frame_csum(HEADER, seq, frame_data);
      default: out_data = 8'h00;
    endcase
  end

  // Stage p1: pending entry, sequencer state, sequence and drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full  <= 1'b0;
      state      <= ST_IDLE;
      seq        <= 8'h00;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      if (load) begin
        pend_full <= 1'b1;
      end else if (consume) begin
        pend_full <= 1'b0;
      end
      if (res_valid && !load) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      if (state == ST_CSUM && accept) begin
        seq <= seq + 8'd1;
      end
      state <= state_nxt;
    end
  end

  // Data registers carry no reset; their contents matter only while flagged valid.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_data <= res_data;
    end
    if (consume) begin
      frame_data <= pend_data;
    end
  end

endmodule
